// File: rtl/fpga_bionic_robot_arm.sv
// Five-finger bionic hand controller: KEY1 presses queue gesture codes, an
// executor holds each gesture for a fixed time, five servo PWMs drive fingers.
// PULSE_CLOSED must be smaller than PWM_PERIOD.
module fpga_bionic_robot_arm #(
   parameter int unsigned PWM_PERIOD   = 1_000_000,
   parameter int unsigned PULSE_OPEN   = 50_000,
   parameter int unsigned PULSE_CLOSED = 100_000,
   parameter int unsigned GESTURE_HOLD = 25_000_000,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic       CLOCK_50,
   input  logic       KEY0,
   input  logic       KEY1,
   input  logic [7:0] SW,
   output logic       pwm1,
   output logic       pwm2,
   output logic       pwm3,
   output logic       pwm4,
   output logic       pwm5
);

   localparam int unsigned CNT_W = $clog2(PWM_PERIOD);
   localparam int unsigned TMR_W = $clog2(GESTURE_HOLD);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned NFING = 5;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);
   localparam logic [CNT_W-1:0] W_OPEN   = CNT_W'(PULSE_OPEN);
   localparam logic [CNT_W-1:0] W_CLOSED = CNT_W'(PULSE_CLOSED);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GESTURE_HOLD - 1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_e;

   // pose bit order {thumb, index, middle, ring, pinky}; 1 = closed
   logic             key_s1_q, key_s2_q, key_prev_q;
   logic             press_c, code_ok_c, push_c, pop_c;
   logic [NFING-1:0] pose_c;
   logic [NFING-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [OCC_W-1:0] occ_q;
   state_e           state_q;
   logic [NFING-1:0] head_q, target_q, closed_q;
   logic [TMR_W-1:0] timer_q;
   logic [CNT_W-1:0] cnt_q;
   logic [NFING-1:0] pwm_q, pwm_d;

   // KEY1 synchronizer and falling-edge detector
   always_ff @(posedge CLOCK_50) begin
      if (!KEY0) begin
         key_s1_q   <= 1'b1;
         key_s2_q   <= 1'b1;
         key_prev_q <= 1'b1;
      end else begin
         key_s1_q   <= KEY1;
         key_s2_q   <= key_s1_q;
         key_prev_q <= key_s2_q;
      end
   end

   assign press_c = key_prev_q & ~key_s2_q;

   // Gesture code to finger pose decode
   always_comb begin
      pose_c    = '0;
      code_ok_c = 1'b1;
      case (SW)
         8'd1:    pose_c = 5'b11111;
         8'd2:    pose_c = 5'b00000;
         8'd3:    pose_c = 5'b10011;
         default: code_ok_c = 1'b0;
      endcase
   end

   assign push_c = press_c & code_ok_c & (occ_q != OCC_FULL);
   assign pop_c  = (state_q == S_IDLE) & (occ_q != '0);

   // Queue storage; stale entries are harmless because pointers are flushed
   always_ff @(posedge CLOCK_50) begin
      if (push_c) mem_q[wr_ptr_q] <= pose_c;
   end

   // Queue pointers and occupancy
   always_ff @(posedge CLOCK_50) begin
      if (!KEY0) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_c, pop_c})
            2'b10:   occ_q <= occ_q + OCC_W'(1);
            2'b01:   occ_q <= occ_q - OCC_W'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   // Gesture executor: pop, load finger targets, hold for the gesture time
   always_ff @(posedge CLOCK_50) begin
      if (!KEY0) begin
         state_q  <= S_IDLE;
         head_q   <= '0;
         target_q <= '0;
         timer_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pop_c) begin
                  head_q  <= mem_q[rd_ptr_q];
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               target_q <= head_q;
               timer_q  <= '0;
               state_q  <= S_HOLD;
            end
            S_HOLD: begin
               timer_q <= timer_q + TMR_W'(1);
               if (timer_q == TMR_LAST) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Per-finger compare; width comes from the live target only at frame start
   always_comb begin
      pwm_d = '0;
      for (int i = 0; i < NFING; i++) begin
         if (cnt_q == '0) pwm_d[i] = cnt_q < (target_q[i] ? W_CLOSED : W_OPEN);
         else             pwm_d[i] = cnt_q < (closed_q[i] ? W_CLOSED : W_OPEN);
      end
   end

   // Shared frame counter, per-frame width latch and registered PWM outputs
   always_ff @(posedge CLOCK_50) begin
      if (!KEY0) begin
         cnt_q    <= '0;
         closed_q <= '0;
         pwm_q    <= '0;
      end else begin
         cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
         if (cnt_q == '0) closed_q <= target_q;
         pwm_q <= pwm_d;
      end
   end

   assign pwm1 = pwm_q[4];
   assign pwm2 = pwm_q[3];
   assign pwm3 = pwm_q[2];
   assign pwm4 = pwm_q[1];
   assign pwm5 = pwm_q[0];

endmodule

// File: tb/tb_fpga_bionic_robot_arm.sv
// Self-checking bench for fpga_bionic_robot_arm: measures every PWM frame and
// compares the sequence of observed poses with a gesture-level queue model.
`timescale 1ns/1ps
module tb_fpga_bionic_robot_arm;

   localparam int unsigned PERIOD   = 500;
   localparam int unsigned P_OPEN   = 25;
   localparam int unsigned P_CLOSED = 50;
   localparam int unsigned HOLD     = 1500;
   localparam int unsigned DEPTH    = 8;
   localparam int unsigned TAIL     = 2500;

   localparam logic [4:0] ROCK     = 5'b11111;
   localparam logic [4:0] PAPER    = 5'b00000;
   localparam logic [4:0] SCISSORS = 5'b10011;

   typedef logic [4:0] pose_q_t [$];

   logic       clk  = 1'b0;
   logic       KEY0 = 1'b0;
   logic       KEY1 = 1'b1;
   logic [7:0] SW   = 8'd0;
   logic       pwm1, pwm2, pwm3, pwm4, pwm5;
   logic [4:0] pwm;

   int n_cmp = 0;
   int n_err = 0;
   logic [4:0] cur_pose;

   always #5 clk = ~clk;

   fpga_bionic_robot_arm #(
      .PWM_PERIOD  (PERIOD),
      .PULSE_OPEN  (P_OPEN),
      .PULSE_CLOSED(P_CLOSED),
      .GESTURE_HOLD(HOLD),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .CLOCK_50(clk),
      .KEY0    (KEY0),
      .KEY1    (KEY1),
      .SW      (SW),
      .pwm1    (pwm1),
      .pwm2    (pwm2),
      .pwm3    (pwm3),
      .pwm4    (pwm4),
      .pwm5    (pwm5)
   );

   assign pwm = {pwm1, pwm2, pwm3, pwm4, pwm5};

   // Frame monitor: a frame runs from one rising edge of pwm1 to the next
   logic [4:0] f_pose [$];
   int         f_len  [$];
   int         f_bad  [$];
   int         m_len;
   int         m_w [5];
   bit         m_act  = 1'b0;
   logic       m_prev = 1'b0;

   always @(negedge clk) begin
      if (!KEY0) begin
         m_act  = 1'b0;
         m_prev = 1'b0;
      end else begin
         if (pwm[4] && !m_prev) begin
            if (m_act) begin
               logic [4:0] p;
               int         bad;
               p   = '0;
               bad = 0;
               for (int c = 0; c < 5; c++) begin
                  if (m_w[c] == P_CLOSED)    p[c] = 1'b1;
                  else if (m_w[c] != P_OPEN) bad++;
               end
               f_pose.push_back(p);
               f_len.push_back(m_len);
               f_bad.push_back(bad);
            end
            m_act = 1'b1;
            m_len = 0;
            for (int c = 0; c < 5; c++) m_w[c] = 0;
         end
         if (m_act) begin
            m_len++;
            for (int c = 0; c < 5; c++) if (pwm[c]) m_w[c]++;
         end
         m_prev = pwm[4];
      end
   end

   // Observed runs of identical poses and the model's expected runs
   logic [4:0] run_pose [$];
   int         run_len  [$];
   logic [4:0] exp_pose [$];
   int         exp_k    [$];

   function automatic logic [5:0] decode(input logic [7:0] code);
      case (code)
         8'd1:    return {1'b1, ROCK};
         8'd2:    return {1'b1, PAPER};
         8'd3:    return {1'b1, SCISSORS};
         default: return 6'b0;
      endcase
   endfunction

   function automatic logic [7:0] pick_code(input logic [4:0] avoid);
      logic [7:0] c;
      logic [5:0] d;
      do begin
         c = 8'($urandom_range(1, 3));
         d = decode(c);
      end while (d[4:0] == avoid);
      return c;
   endfunction

   task automatic build_runs(input int start);
      run_pose.delete();
      run_len.delete();
      for (int i = start; i < f_pose.size(); i++) begin
         if (run_pose.size() == 0 || f_pose[i] != run_pose[run_pose.size()-1]) begin
            run_pose.push_back(f_pose[i]);
            run_len.push_back(1);
         end else begin
            run_len[run_len.size()-1]++;
         end
      end
   endtask

   task automatic build_model(input pose_q_t seq);
      exp_pose.delete();
      exp_k.delete();
      foreach (seq[i]) begin
         if (exp_pose.size() == 0 || seq[i] != exp_pose[exp_pose.size()-1]) begin
            exp_pose.push_back(seq[i]);
            exp_k.push_back(1);
         end else begin
            exp_k[exp_k.size()-1]++;
         end
      end
   endtask

   task automatic press(input logic [7:0] code, input int low_clks);
      @(posedge clk); #2;
      SW   = code;
      KEY1 = 1'b0;
      repeat (low_clks) @(posedge clk);
      #2;
      KEY1 = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic test_reset();
      int start;
      KEY0 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); @(negedge clk);
         n_cmp++;
         if (pwm !== 5'b0) begin
            n_err++;
            $display("FAIL reset_low[%0d]: pwm=%b required 00000", i, pwm);
         end
      end
      @(posedge clk); #2;
      KEY0  = 1'b1;
      start = f_pose.size();
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (pwm !== 5'b11111) begin
         n_err++;
         $display("FAIL reset_first_frame: pwm=%b required 11111", pwm);
      end
      repeat (4 * PERIOD) @(posedge clk);
      n_cmp++;
      if (f_pose.size() - start < 3) begin
         n_err++;
         $display("FAIL reset_frames: got %0d frames required >=3", f_pose.size() - start);
      end
      for (int i = start; i < f_pose.size(); i++) begin
         n_cmp++;
         if (f_pose[i] !== PAPER || f_bad[i] != 0 || f_len[i] != PERIOD) begin
            n_err++;
            $display("FAIL reset_open[%0d]: pose=%b len=%0d bad=%0d required pose=00000 len=%0d bad=0",
                     i, f_pose[i], f_len[i], f_bad[i], PERIOD);
         end
      end
      cur_pose = PAPER;
   endtask

   task automatic test_single();
      int      start;
      pose_q_t seq;
      start = f_pose.size();
      seq   = {cur_pose};
      press(8'd1, 5);
      seq.push_back(ROCK);
      repeat (HOLD + TAIL) @(posedge clk);
      build_runs(start);
      build_model(seq);
      for (int i = start; i < f_pose.size(); i++) begin
         n_cmp++;
         if (f_bad[i] != 0 || f_len[i] != PERIOD) begin
            n_err++;
            $display("FAIL single_frame[%0d]: len=%0d bad=%0d required len=%0d bad=0", i, f_len[i], f_bad[i], PERIOD);
         end
      end
      n_cmp++;
      if (run_pose.size() != exp_pose.size()) begin
         n_err++;
         $display("FAIL single_runs: got %0d pose runs required %0d", run_pose.size(), exp_pose.size());
      end
      for (int i = 0; i < run_pose.size() && i < exp_pose.size(); i++) begin
         n_cmp++;
         if (run_pose[i] !== exp_pose[i]) begin
            n_err++;
            $display("FAIL single_pose[%0d]: got %b required %b", i, run_pose[i], exp_pose[i]);
         end
      end
      if (run_len.size() > 0) begin
         n_cmp++;
         if (run_len[run_len.size()-1] < TAIL / PERIOD) begin
            n_err++;
            $display("FAIL single_retain: last pose %0d frames required >=%0d", run_len[run_len.size()-1], TAIL / PERIOD);
         end
      end
      cur_pose = exp_pose[exp_pose.size()-1];
   endtask

   task automatic test_queue();
      int         start;
      pose_q_t    seq;
      logic [7:0] codes [3];
      logic [5:0] d;
      start = f_pose.size();
      seq   = {cur_pose};
      codes = '{8'd1, 8'd2, 8'd3};
      foreach (codes[i]) begin
         press(codes[i], 5);
         d = decode(codes[i]);
         seq.push_back(d[4:0]);
         repeat (40) @(posedge clk);
      end
      repeat (3 * (HOLD + 2) + TAIL) @(posedge clk);
      build_runs(start);
      build_model(seq);
      for (int i = start; i < f_pose.size(); i++) begin
         n_cmp++;
         if (f_bad[i] != 0 || f_len[i] != PERIOD) begin
            n_err++;
            $display("FAIL queue_frame[%0d]: len=%0d bad=%0d required len=%0d bad=0", i, f_len[i], f_bad[i], PERIOD);
         end
      end
      n_cmp++;
      if (run_pose.size() != exp_pose.size()) begin
         n_err++;
         $display("FAIL queue_runs: got %0d pose runs required %0d", run_pose.size(), exp_pose.size());
      end
      for (int i = 0; i < run_pose.size() && i < exp_pose.size(); i++) begin
         n_cmp++;
         if (run_pose[i] !== exp_pose[i]) begin
            n_err++;
            $display("FAIL queue_pose[%0d]: got %b required %b", i, run_pose[i], exp_pose[i]);
         end
         if (i > 0 && i < exp_pose.size() - 1) begin
            int lo;
            lo = (exp_k[i] * (HOLD + 2)) / PERIOD;
            n_cmp++;
            if (run_len[i] != lo && run_len[i] != lo + 1) begin
               n_err++;
               $display("FAIL queue_hold[%0d]: %0d frames required %0d or %0d", i, run_len[i], lo, lo + 1);
            end
         end
      end
      cur_pose = exp_pose[exp_pose.size()-1];
   endtask

   task automatic test_invalid_longpress();
      int         start;
      pose_q_t    seq;
      logic [7:0] a, b, bad_code;
      logic [5:0] d;
      start = f_pose.size();
      seq   = {cur_pose};
      press(8'd0, 5);
      press(8'd7, 5);
      for (int i = 0; i < 3; i++) begin
         bad_code = 8'($urandom_range(4, 255));
         press(bad_code, 5);
      end
      repeat (2 * PERIOD) @(posedge clk);
      a = pick_code(cur_pose);
      d = decode(a);
      b = pick_code(d[4:0]);
      press(a, 100);
      seq.push_back(d[4:0]);
      press(b, 5);
      d = decode(b);
      seq.push_back(d[4:0]);
      repeat (2 * (HOLD + 2) + TAIL) @(posedge clk);
      build_runs(start);
      build_model(seq);
      for (int i = start; i < f_pose.size(); i++) begin
         n_cmp++;
         if (f_bad[i] != 0 || f_len[i] != PERIOD) begin
            n_err++;
            $display("FAIL invalid_frame[%0d]: len=%0d bad=%0d required len=%0d bad=0", i, f_len[i], f_bad[i], PERIOD);
         end
      end
      n_cmp++;
      if (run_pose.size() != exp_pose.size()) begin
         n_err++;
         $display("FAIL invalid_runs: got %0d pose runs required %0d", run_pose.size(), exp_pose.size());
      end
      for (int i = 0; i < run_pose.size() && i < exp_pose.size(); i++) begin
         n_cmp++;
         if (run_pose[i] !== exp_pose[i]) begin
            n_err++;
            $display("FAIL invalid_pose[%0d]: got %b required %b", i, run_pose[i], exp_pose[i]);
         end
         if (i > 0 && i < exp_pose.size() - 1) begin
            int lo;
            lo = (exp_k[i] * (HOLD + 2)) / PERIOD;
            n_cmp++;
            if (run_len[i] != lo && run_len[i] != lo + 1) begin
               n_err++;
               $display("FAIL longpress_hold[%0d]: %0d frames required %0d or %0d", i, run_len[i], lo, lo + 1);
            end
         end
      end
      cur_pose = exp_pose[exp_pose.size()-1];
   endtask

   task automatic test_overflow();
      int         start;
      pose_q_t    seq;
      logic [4:0] model_q [$];
      logic [7:0] g0, c;
      logic [5:0] d;
      start = f_pose.size();
      seq   = {cur_pose};
      g0    = pick_code(cur_pose);
      d     = decode(g0);
      press(g0, 5);
      seq.push_back(d[4:0]);
      repeat (20) @(posedge clk);
      for (int i = 0; i < 10; i++) begin
         c = pick_code(d[4:0]);
         d = decode(c);
         press(c, 3);
         if (model_q.size() < DEPTH) model_q.push_back(d[4:0]);
      end
      foreach (model_q[i]) seq.push_back(model_q[i]);
      repeat ((DEPTH + 1) * (HOLD + 2) + TAIL) @(posedge clk);
      build_runs(start);
      build_model(seq);
      for (int i = start; i < f_pose.size(); i++) begin
         n_cmp++;
         if (f_bad[i] != 0 || f_len[i] != PERIOD) begin
            n_err++;
            $display("FAIL overflow_frame[%0d]: len=%0d bad=%0d required len=%0d bad=0", i, f_len[i], f_bad[i], PERIOD);
         end
      end
      n_cmp++;
      if (run_pose.size() != exp_pose.size()) begin
         n_err++;
         $display("FAIL overflow_runs: got %0d pose runs required %0d", run_pose.size(), exp_pose.size());
      end
      for (int i = 0; i < run_pose.size() && i < exp_pose.size(); i++) begin
         n_cmp++;
         if (run_pose[i] !== exp_pose[i]) begin
            n_err++;
            $display("FAIL overflow_pose[%0d]: got %b required %b", i, run_pose[i], exp_pose[i]);
         end
         if (i > 0 && i < exp_pose.size() - 1) begin
            int lo;
            lo = (exp_k[i] * (HOLD + 2)) / PERIOD;
            n_cmp++;
            if (run_len[i] != lo && run_len[i] != lo + 1) begin
               n_err++;
               $display("FAIL overflow_hold[%0d]: %0d frames required %0d or %0d", i, run_len[i], lo, lo + 1);
            end
         end
      end
      cur_pose = exp_pose[exp_pose.size()-1];
   endtask

   task automatic test_reset_mid_hold();
      int start;
      int min_frames;
      press(8'd1, 5);
      repeat (50) @(posedge clk);
      press(($urandom_range(0, 1) != 0) ? 8'd1 : 8'd3, 5);
      repeat (50) @(posedge clk);
      press(($urandom_range(0, 1) != 0) ? 8'd1 : 8'd3, 5);
      repeat (600) @(posedge clk);
      #2;
      KEY0 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); @(negedge clk);
         n_cmp++;
         if (pwm !== 5'b0) begin
            n_err++;
            $display("FAIL midreset_low[%0d]: pwm=%b required 00000", i, pwm);
         end
      end
      @(posedge clk); #2;
      KEY0  = 1'b1;
      start = f_pose.size();
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (pwm !== 5'b11111) begin
         n_err++;
         $display("FAIL midreset_first_frame: pwm=%b required 11111", pwm);
      end
      repeat (2 * (HOLD + 2) + TAIL) @(posedge clk);
      min_frames = (2 * (HOLD + 2) + TAIL) / PERIOD - 2;
      n_cmp++;
      if (f_pose.size() - start < min_frames) begin
         n_err++;
         $display("FAIL midreset_frames: got %0d frames required >=%0d", f_pose.size() - start, min_frames);
      end
      for (int i = start; i < f_pose.size(); i++) begin
         n_cmp++;
         if (f_pose[i] !== PAPER || f_bad[i] != 0 || f_len[i] != PERIOD) begin
            n_err++;
            $display("FAIL midreset_open[%0d]: pose=%b len=%0d bad=%0d required pose=00000 len=%0d bad=0",
                     i, f_pose[i], f_len[i], f_bad[i], PERIOD);
         end
      end
      cur_pose = PAPER;
   endtask

   initial begin
      cur_pose = PAPER;
      test_reset();
      test_single();
      test_queue();
      test_invalid_longpress();
      test_overflow();
      test_reset_mid_hold();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
